// File: rtl/adder_share_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : adder_share_arbiter
// Brief   : Round-robin sharing of one pipelined adder/subtractor between two
//           requesters, with a requester-ID tag pipeline to route results.
// Revision: 1.0 - initial release
// ============================================================================
module adder_share_arbiter #(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 2
) (
   input  logic             clk,
   input  logic             AReset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic             req0_sub,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic             req1_sub,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             adder_add_sub,
   output logic [WIDTH-1:0] adder_dataa,
   output logic [WIDTH-1:0] adder_datab,
   input  logic [WIDTH-1:0] adder_result,
   output logic             rsp0_valid,
   output logic [WIDTH-1:0] rsp0_data,
   output logic             rsp1_valid,
   output logic [WIDTH-1:0] rsp1_data
);

   // Last tag stage lines up with adder_result for the op it tracks.
   localparam int c_LAST = LATENCY;

   logic             r_rr_ptr;
   logic [c_LAST:0]  r_tag_vld;
   logic [c_LAST:0]  r_tag_id;
   logic             w_issue;
   logic             w_rsp0_hit;
   logic             w_rsp1_hit;

   assign req0_ready = AReset & req0_valid & (~req1_valid | ~r_rr_ptr);
   assign req1_ready = AReset & req1_valid & (~req0_valid |  r_rr_ptr);
   assign w_issue    = req0_ready | req1_ready;

   assign w_rsp0_hit = r_tag_vld[c_LAST] & ~r_tag_id[c_LAST];
   assign w_rsp1_hit = r_tag_vld[c_LAST] &  r_tag_id[c_LAST];

   always_ff @(posedge clk) begin
      if (!AReset) begin
         r_rr_ptr      <= 1'b0;
         r_tag_vld     <= '0;
         r_tag_id      <= '0;
         adder_add_sub <= 1'b1;
         adder_dataa   <= '0;
         adder_datab   <= '0;
         rsp0_valid    <= 1'b0;
         rsp0_data     <= '0;
         rsp1_valid    <= 1'b0;
         rsp1_data     <= '0;
      end else begin
         if (w_issue) begin
            // Priority passes to the requester that was not just served.
            r_rr_ptr <= req0_ready;
            if (req0_ready) begin
               adder_dataa   <= req0_a;
               adder_datab   <= req0_b;
               adder_add_sub <= ~req0_sub;
            end else begin
               adder_dataa   <= req1_a;
               adder_datab   <= req1_b;
               adder_add_sub <= ~req1_sub;
            end
         end

         r_tag_vld <= {r_tag_vld[c_LAST-1:0], w_issue};
         r_tag_id  <= {r_tag_id[c_LAST-1:0], req1_ready};

         rsp0_valid <= w_rsp0_hit;
         rsp1_valid <= w_rsp1_hit;
         if (w_rsp0_hit) begin
            rsp0_data <= adder_result;
         end
         if (w_rsp1_hit) begin
            rsp1_data <= adder_result;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_adder_share_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_adder_share_arbiter
// Brief   : Directed bench with a queue-based reference model for the shared
//           adder arbiter, plus a LATENCY=3 instance.
// Revision: 1.0 - initial release
// ============================================================================
module tb_adder_share_arbiter;
   localparam int W  = 32;
   localparam int L  = 2;
   localparam int L3 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          AReset = 1'b0;
   logic          req0_valid = 1'b0, req0_sub = 1'b0;
   logic          req1_valid = 1'b0, req1_sub = 1'b0;
   logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic          req0_ready, req1_ready, adder_add_sub, rsp0_valid, rsp1_valid;
   logic [W-1:0]  adder_dataa, adder_datab, adder_result, rsp0_data, rsp1_data;

   // Second instance exercising a 3-deep adder; only requester 0 is used.
   logic          l3_valid = 1'b0, l3_sub = 1'b0, l3_zero = 1'b0;
   logic [W-1:0]  l3_a = '0, l3_b = '0, l3_zw = '0;
   logic          l3_ready, l3_ready1, l3_add_sub, l3_rv0, l3_rv1;
   logic [W-1:0]  l3_dataa, l3_datab, l3_result, l3_rd0, l3_rd1;

   adder_share_arbiter #(.WIDTH(W), .LATENCY(L)) dut (
      .clk(clk), .AReset(AReset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sub(req0_sub),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sub(req1_sub),
      .req1_a(req1_a), .req1_b(req1_b),
      .adder_add_sub(adder_add_sub), .adder_dataa(adder_dataa),
      .adder_datab(adder_datab), .adder_result(adder_result),
      .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
      .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data)
   );

   adder_share_arbiter #(.WIDTH(W), .LATENCY(L3)) dut3 (
      .clk(clk), .AReset(AReset),
      .req0_valid(l3_valid), .req0_ready(l3_ready), .req0_sub(l3_sub),
      .req0_a(l3_a), .req0_b(l3_b),
      .req1_valid(l3_zero), .req1_ready(l3_ready1), .req1_sub(l3_zero),
      .req1_a(l3_zw), .req1_b(l3_zw),
      .adder_add_sub(l3_add_sub), .adder_dataa(l3_dataa),
      .adder_datab(l3_datab), .adder_result(l3_result),
      .rsp0_valid(l3_rv0), .rsp0_data(l3_rd0),
      .rsp1_valid(l3_rv1), .rsp1_data(l3_rd1)
   );

   // Pipelined adder models (no reset, like a plain LPM pipe).
   logic [W-1:0] add_pipe  [L];
   logic [W-1:0] add_pipe3 [L3];
   always @(posedge clk) begin
      add_pipe[0]  <= adder_add_sub ? adder_dataa + adder_datab : adder_dataa - adder_datab;
      for (int k = 1; k < L; k++) add_pipe[k] <= add_pipe[k-1];
      add_pipe3[0] <= l3_add_sub ? l3_dataa + l3_datab : l3_dataa - l3_datab;
      for (int k = 1; k < L3; k++) add_pipe3[k] <= add_pipe3[k-1];
   end
   assign adder_result = add_pipe[L-1];
   assign l3_result    = add_pipe3[L3-1];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each accepted op becomes a queue entry due at a cycle.
   typedef struct {
      int           due;
      bit           id;
      logic [W-1:0] res;
   } pend_t;
   pend_t        pend[$];
   int           cyc      = 0;
   bit           model_ok = 1'b0;
   bit           e_turn1  = 1'b0;
   logic         e_as = 1'b1, e_rv0 = 1'b0, e_rv1 = 1'b0;
   logic [W-1:0] e_da = '0, e_db = '0, e_rd0 = '0, e_rd1 = '0;

   always @(negedge clk) begin : compare
      logic         g0, g1;
      logic [W-1:0] r;
      cyc++;
      if (!AReset) begin
         g0 = 1'b0; g1 = 1'b0;
      end else if (req0_valid && req1_valid) begin
         g0 = !e_turn1; g1 = e_turn1;
      end else begin
         g0 = req0_valid; g1 = req1_valid;
      end

      if (model_ok) begin
         chk("ready0", req0_ready, g0);
         chk("ready1", req1_ready, g1);
         chk("both_ready", req0_ready & req1_ready, 0);
         chk("dataa", adder_dataa, e_da);
         chk("datab", adder_datab, e_db);
         chk("add_sub", adder_add_sub, e_as);
         chk("rsp0_valid", rsp0_valid, e_rv0);
         chk("rsp1_valid", rsp1_valid, e_rv1);
         chk("rsp0_data", rsp0_data, e_rd0);
         chk("rsp1_data", rsp1_data, e_rd1);
      end

      if (!AReset) begin
         model_ok = 1'b1;
         pend.delete();
         e_turn1 = 1'b0; e_as = 1'b1; e_da = '0; e_db = '0;
         e_rv0 = 1'b0; e_rv1 = 1'b0; e_rd0 = '0; e_rd1 = '0;
      end else if (model_ok) begin
         if (g0 || g1) begin
            if (g0) begin
               r = req0_sub ? req0_a - req0_b : req0_a + req0_b;
               e_da = req0_a; e_db = req0_b; e_as = !req0_sub;
            end else begin
               r = req1_sub ? req1_a - req1_b : req1_a + req1_b;
               e_da = req1_a; e_db = req1_b; e_as = !req1_sub;
            end
            pend.push_back(pend_t'{due: cyc + L + 2, id: g1, res: r});
            e_turn1 = g0;
         end
         e_rv0 = 1'b0; e_rv1 = 1'b0;
         if (pend.size() > 0 && pend[0].due == cyc + 1) begin
            if (pend[0].id) begin e_rv1 = 1'b1; e_rd1 = pend[0].res; end
            else            begin e_rv0 = 1'b1; e_rd0 = pend[0].res; end
            void'(pend.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      AReset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; l3_valid = 1'b0;
      step();
      AReset = 1'b1;
   endtask

   initial begin
      step(); step();

      // Requester 0 add 0+5.
      do_reset();
      req0_valid = 1; req0_sub = 0; req0_a = 0; req0_b = 5;
      #3 chk("t1_ready0", req0_ready, 1);
      step();
      req0_valid = 0;
      chk("t1_dataa", adder_dataa, 0);
      chk("t1_datab", adder_datab, 5);
      chk("t1_add_sub", adder_add_sub, 1);
      step(); step();
      chk("t1_rsp0_early", rsp0_valid, 0);
      step();
      chk("t1_rsp0_valid", rsp0_valid, 1);
      chk("t1_rsp0_data", rsp0_data, 5);
      chk("t1_rsp1_valid", rsp1_valid, 0);
      step();
      chk("t1_rsp0_drop", rsp0_valid, 0);

      // Requester 1 subtract 7-9 wraps modulo 2^32.
      do_reset();
      req1_valid = 1; req1_sub = 1; req1_a = 7; req1_b = 9;
      #3 chk("t2_ready1", req1_ready, 1);
      step();
      req1_valid = 0;
      chk("t2_add_sub", adder_add_sub, 0);
      step(); step(); step();
      chk("t2_rsp1_valid", rsp1_valid, 1);
      chk("t2_rsp1_data", rsp1_data, 32'hFFFF_FFFE);

      // Both requesters valid for 6 cycles: grants and responses alternate.
      do_reset();
      begin
         int n0, n1;
         n0 = 0; n1 = 0;
         for (int k = 0; k < 11; k++) begin
            req0_valid = (k < 6); req1_valid = (k < 6);
            req0_sub = 0; req1_sub = 0;
            req0_a = 2*n0 + 1; req0_b = 2*n0 + 1;
            req1_a = 2*n1 + 2; req1_b = 2*n1 + 2;
            #3;
            if (k < 6) begin
               chk("t3_ready0", req0_ready, (k % 2 == 0));
               chk("t3_ready1", req1_ready, (k % 2 == 1));
            end
            if (k >= 4 && k < 10) begin
               if ((k - 4) % 2 == 0) begin
                  chk("t3_rsp0_valid", rsp0_valid, 1);
                  chk("t3_rsp0_data", rsp0_data, 2*(k - 3));
               end else begin
                  chk("t3_rsp1_valid", rsp1_valid, 1);
                  chk("t3_rsp1_data", rsp1_data, 2*(k - 3));
               end
            end
            if (req0_ready) n0++;
            if (req1_ready) n1++;
            step();
         end
      end

      // Requester 0 back-to-back: a=i, b=10.
      do_reset();
      for (int k = 0; k < 9; k++) begin
         req0_valid = (k < 4); req0_sub = 0; req0_a = k; req0_b = 10;
         #3;
         if (k < 4) chk("t4_ready0", req0_ready, 1);
         if (k >= 4 && k < 8) begin
            chk("t4_rsp0_valid", rsp0_valid, 1);
            chk("t4_rsp0_data", rsp0_data, 10 + k - 4);
         end
         if (k == 8) chk("t4_rsp0_end", rsp0_valid, 0);
         step();
      end

      // Reset in the middle of two in-flight ops discards them.
      do_reset();
      req0_valid = 1; req0_sub = 0; req0_a = 1; req0_b = 1;
      step();
      req0_a = 2; req0_b = 2;
      step();
      AReset = 0;
      #3 chk("t5_ready0_in_reset", req0_ready, 0);
      step();
      AReset = 1; req0_valid = 0;
      chk("t5_dataa", adder_dataa, 0);
      chk("t5_datab", adder_datab, 0);
      chk("t5_add_sub", adder_add_sub, 1);
      chk("t5_rsp0_data", rsp0_data, 0);
      for (int k = 0; k < 6; k++) begin
         chk("t5_rsp0_quiet", rsp0_valid, 0);
         chk("t5_rsp1_quiet", rsp1_valid, 0);
         step();
      end
      req0_valid = 1; req1_valid = 1; req0_a = 3; req0_b = 3; req1_a = 4; req1_b = 4;
      #3;
      chk("t5_first_grant0", req0_ready, 1);
      chk("t5_first_grant1", req1_ready, 0);
      step();
      req0_valid = 0;
      step();
      req1_valid = 0;
      repeat (6) step();

      // LATENCY=3 instance: 3+4 answers at T+5.
      do_reset();
      l3_valid = 1; l3_sub = 0; l3_a = 3; l3_b = 4;
      #3 chk("t6_ready", l3_ready, 1);
      step();
      l3_valid = 0;
      step(); step(); step();
      chk("t6_rsp0_early", l3_rv0, 0);
      step();
      chk("t6_rsp0_valid", l3_rv0, 1);
      chk("t6_rsp0_data", l3_rd0, 7);
      chk("t6_rsp1_valid", l3_rv1, 0);
      step();
      chk("t6_rsp0_drop", l3_rv0, 0);

      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
Shares one pipelined LPM adder/subtractor between two independent requesters, e.g. the ALU and the branch-target unit. Arbitration is round-robin with one issue per cycle. The block registers operands into the adder and tracks in-flight operations with a requester-ID tag pipeline matched to the adder latency. Each result returns on the issuing requester's response port, in issue order.

Parameters:
WIDTH, 32, operand/result width in bits
LATENCY, 2, adder pipeline depth: clock edges from adder_dataa/datab/add_sub sampled to adder_result valid (≥1)

Ports:
clk  in  1  system clock, rising edge
AReset  in  1  synchronous reset, active-low (0 = reset, sampled on rising clk)
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 granted this cycle
req0_sub  in  1  1 = A−B, 0 = A+B
req0_a  in  WIDTH  operand A
req0_b  in  WIDTH  operand B
req1_valid, req1_ready, req1_sub, req1_a, req1_b  same as requester 0, for requester 1
adder_add_sub  out  1  to adder: 1 = add, 0 = subtract
adder_dataa  out  WIDTH  to adder operand A
adder_datab  out  WIDTH  to adder operand B
adder_result  in  WIDTH  from adder
rsp0_valid  out  1  one-cycle pulse: rsp0_data holds requester 0's result
rsp0_data  out  WIDTH  result for requester 0
rsp1_valid, rsp1_data  same as rsp0, for requester 1

Behaviour:
- Reset (AReset=0 at a rising edge): adder_add_sub=1, adder_dataa=0, adder_datab=0, rsp0/1_valid=0, rsp0/1_data=0, rr_ptr=0, all tag-pipeline valids=0. In-flight operations are discarded and produce no response, even if adder_result later changes.
- Grant is combinational:
  - req0_ready = req0_valid & (~req1_valid | rr_ptr==0)
  - req1_ready = req1_valid & (~req0_valid | rr_ptr==1)
  - At most one ready per cycle. A ready is never asserted without its own valid.
  - Both ready outputs are 0 while AReset=0.
- Handshake = valid & ready. The requester must hold valid and its operands until its handshake.
- rr_ptr update on a grant to requester i: rr_ptr ← ~i. No grant: rr_ptr holds.
  - Single requester: granted every cycle.
  - Both requesters continuously valid: grants alternate 0,1,0,1...
- Issue stage, on the edge ending handshake cycle T:
  - adder_dataa ← a, adder_datab ← b, adder_add_sub ← ~sub.
  - Tag stage 0 ← {valid=1, id=i}.
  - With no handshake, adder_* registers hold their values and tag stage 0 valid ← 0.
- Tag pipeline: LATENCY+1 stages of {valid, id}, shifting every cycle. The final stage aligns with adder_result valid during cycle T+1+LATENCY.
- Response:
  - On the edge ending cycle T+1+LATENCY, if the final tag is valid: rsp<id>_data ← adder_result and rsp<id>_valid ← 1 for exactly the next cycle (T+2+LATENCY).
  - The other requester's rsp_valid ← 0.
  - rsp_data holds its value when not updated.
  - Total latency: handshake cycle T → response cycle T+LATENCY+2 (T+4 at default).
- Throughput: one operation per cycle sustained. No backpressure on responses; the consumer must accept every pulse.
- Arithmetic: the adder is modulo 2^WIDTH. The block does no widening, overflow detection or saturation.
- Ordering: responses leave in global issue order. Per-requester order is preserved.

Test Plan:
- Reset, then req0 add, a=0, b=5, asserted cycle 0 → req0_ready=1 in cycle 0; adder_dataa=0, adder_datab=5, adder_add_sub=1 in cycle 1; rsp0_valid=1 with rsp0_data=5 in cycle 4 only; rsp1_valid stays 0.
- req1 sub, a=7, b=9 → rsp1_data=32'hFFFFFFFE, rsp1_valid pulse at T+4; adder_add_sub=0 during T+1.
- Both requesters valid continuously for 6 cycles, operands 1..6 → ready alternates starting with req0 (rr_ptr=0 after reset); responses alternate rsp0, rsp1 from T+4 with the matching sums; no cycle with both ready.
- req0 alone, back-to-back for 4 cycles with a=i, b=10 → rsp0_valid high 4 consecutive cycles with 10, 11, 12, 13.
- Issue 2 ops, assert AReset=0 for 1 cycle at T+2 → no rsp*_valid for the next 6 cycles; all outputs at reset values; the first grant after reset goes to req0.
- LATENCY=3 (adder model with 3-stage pipe), req0 3+4 → rsp0_valid=1 with rsp0_data=7 in cycle T+5.
